// File: rtl/exp_arbiter.sv
// Two-requester front end for a shared modular-exponentiation engine.
// Grants one job at a time, forwards registered operands to the engine,
// times the job and holds each requester's result until it is acknowledged.
module exp_arbiter #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  // requester 0
  input  logic              req_0,
  input  logic [DATA_W-1:0] x_0,
  input  logic [DATA_W-1:0] e_0,
  input  logic [DATA_W-1:0] m_0,
  input  logic [DATA_W-1:0] rmodm_0,
  input  logic [DATA_W-1:0] r2modm_0,
  input  logic              mul_en_0,
  output logic              gnt_0,
  output logic              res_valid_0,
  output logic [DATA_W-1:0] result_0,
  input  logic              res_ack_0,
  // requester 1
  input  logic              req_1,
  input  logic [DATA_W-1:0] x_1,
  input  logic [DATA_W-1:0] e_1,
  input  logic [DATA_W-1:0] m_1,
  input  logic [DATA_W-1:0] rmodm_1,
  input  logic [DATA_W-1:0] r2modm_1,
  input  logic              mul_en_1,
  output logic              gnt_1,
  output logic              res_valid_1,
  output logic [DATA_W-1:0] result_1,
  input  logic              res_ack_1,
  // engine side
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_x,
  output logic [DATA_W-1:0] eng_e,
  output logic [DATA_W-1:0] eng_m,
  output logic [DATA_W-1:0] eng_rmodm,
  output logic [DATA_W-1:0] eng_r2modm,
  output logic              eng_mul_en,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  // status
  output logic              owner,
  output logic [CNT_W-1:0]  last_latency
);

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StDrain} state_t;

  state_t             state_q, state_d;
  logic               owner_q;
  logic [CNT_W-1:0]   cnt_q, last_lat_q;
  logic               res_valid_0_q, res_valid_1_q;
  logic [DATA_W-1:0]  result_0_q, result_1_q;
  logic [DATA_W-1:0]  eng_x_q, eng_e_q, eng_m_q, eng_rmodm_q, eng_r2modm_q;
  logic               eng_mul_en_q;

  logic elig_0, elig_1, any_elig, winner, grant_load, capture;

  // Eligibility and round-robin pick: on a tie the non-owner wins.
  always_comb begin
    elig_0   = req_0 & ~res_valid_0_q;
    elig_1   = req_1 & ~res_valid_1_q;
    any_elig = elig_0 | elig_1;
    winner   = (elig_0 & elig_1) ? ~owner_q : elig_1;
  end

  // Next-state and pulse outputs; grant is combinational in IDLE only.
  always_comb begin
    state_d    = state_q;
    gnt_0      = 1'b0;
    gnt_1      = 1'b0;
    eng_start  = 1'b0;
    grant_load = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by resetn so no grant leaks out while reset is held.
        if (resetn && any_elig) begin
          grant_load = 1'b1;
          gnt_0      = ~winner;
          gnt_1      = winner;
          state_d    = StStart;
        end
      end
      StStart: begin
        eng_start = 1'b1;
        state_d   = StBusy;
      end
      StBusy: begin
        if (eng_done) begin
          capture = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait for done to drop so a held level is not taken as a new completion.
        if (!eng_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, owner and engine operand registers; operands held until the next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b1;
      eng_x_q      <= '0;
      eng_e_q      <= '0;
      eng_m_q      <= '0;
      eng_rmodm_q  <= '0;
      eng_r2modm_q <= '0;
      eng_mul_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        owner_q      <= winner;
        eng_x_q      <= winner ? x_1      : x_0;
        eng_e_q      <= winner ? e_1      : e_0;
        eng_m_q      <= winner ? m_1      : m_0;
        eng_rmodm_q  <= winner ? rmodm_1  : rmodm_0;
        eng_r2modm_q <= winner ? r2modm_1 : r2modm_0;
        eng_mul_en_q <= winner ? mul_en_1 : mul_en_0;
      end
    end
  end

  // Saturating BUSY-cycle counter and latency capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      last_lat_q <= '0;
    end else begin
      if (state_q == StStart) begin
        cnt_q <= '0;
      end else if (state_q == StBusy && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture) last_lat_q <= cnt_q;
    end
  end

  // Per-requester result holding; capture of a result takes priority over ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_valid_0_q <= 1'b0;
      res_valid_1_q <= 1'b0;
      result_0_q    <= '0;
      result_1_q    <= '0;
    end else begin
      if (capture && !owner_q) begin
        result_0_q    <= eng_result;
        res_valid_0_q <= 1'b1;
      end else if (res_ack_0) begin
        res_valid_0_q <= 1'b0;
      end
      if (capture && owner_q) begin
        result_1_q    <= eng_result;
        res_valid_1_q <= 1'b1;
      end else if (res_ack_1) begin
        res_valid_1_q <= 1'b0;
      end
    end
  end

  assign res_valid_0  = res_valid_0_q;
  assign res_valid_1  = res_valid_1_q;
  assign result_0     = result_0_q;
  assign result_1     = result_1_q;
  assign eng_x        = eng_x_q;
  assign eng_e        = eng_e_q;
  assign eng_m        = eng_m_q;
  assign eng_rmodm    = eng_rmodm_q;
  assign eng_r2modm   = eng_r2modm_q;
  assign eng_mul_en   = eng_mul_en_q;
  assign owner        = owner_q;
  assign last_latency = last_lat_q;

endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter: DATA_W, default 512, operand/result width.
REQ-002 Parameter: CNT_W, default 16, latency counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req_i (i=0,1)  input  1  level request from requester i.
REQ-006 x_i, e_i, m_i, rmodm_i, r2modm_i (i=0,1)  input  DATA_W each  base, exponent, modulus, R mod m, R^2 mod m; stable while req_i high.
REQ-007 mul_en_i (i=0,1)  input  1  multiplication_enable value for requester i.
REQ-008 gnt_i (i=0,1)  output  1  one-cycle pulse; operands of i sampled this cycle.
REQ-009 res_valid_i (i=0,1)  output  1  result_i holds an unacknowledged result.
REQ-010 result_i (i=0,1)  output  DATA_W  last result for requester i.
REQ-011 res_ack_i (i=0,1)  input  1  consumes result_i.
REQ-012 eng_start  output  1  start pulse to exponentiation engine.
REQ-013 eng_x, eng_e, eng_m, eng_rmodm, eng_r2modm  output  DATA_W each  registered operands to engine.
REQ-014 eng_mul_en  output  1  registered multiplication_enable to engine.
REQ-015 eng_done  input  1  engine completion (level, may stay high).
REQ-016 eng_result  input  DATA_W  engine result, valid while eng_done=1.
REQ-017 owner  output  1  index of requester currently/last granted.
REQ-018 last_latency  output  CNT_W  cycles spent in BUSY by the last completed job.

Function
REQ-019 FSM states: IDLE, START, BUSY, DRAIN.
REQ-020 Requester i is eligible when req_i=1 and res_valid_i=0.
REQ-021 IDLE: if any eligible, gnt of winner=1 (combinational, same cycle), winner's operands and mul_en latched into eng_* registers, owner<=winner, next START; else stay IDLE, no gnt.
REQ-022 Arbitration: single eligible wins; both eligible -> requester != owner wins (round-robin); owner resets to 1 so requester 0 wins the first tie.
REQ-023 START: eng_start=1 for exactly this cycle, counter cleared, next BUSY.
REQ-024 BUSY: counter increments per cycle, saturating at 2^CNT_W-1; when eng_done=1, result_owner<=eng_result, res_valid_owner<=1, last_latency<=counter, next DRAIN.
REQ-025 DRAIN: stay until eng_done=0, then IDLE; prevents stale done being taken as next completion.
REQ-026 eng_done in IDLE or START ignored.
REQ-027 eng_* operand outputs stable from START until next grant.
REQ-028 res_ack_i with res_valid_i=1 clears res_valid_i at next edge; result_i retains value; ack with res_valid_i=0 has no effect.
REQ-029 Ack and new result for same requester in same cycle cannot occur (ineligible); ack of requester j during other's BUSY/capture processed independently.
REQ-030 At most one gnt per job; gnt never asserted outside IDLE.
REQ-031 Minimum latency gnt -> res_valid: gnt in cycle t, eng_start t+1, res_valid high after edge of first cycle in BUSY with eng_done=1 (earliest t+3).

Reset
REQ-032 resetn=0 asynchronously forces: state IDLE, gnt_i=0, eng_start=0, res_valid_i=0, result_i=0, eng_* operands=0, eng_mul_en=0, owner=1, last_latency=0, counter=0.
REQ-033 Reset mid-job abandons the job; no result delivered; operation resumes from IDLE after release.

Verification
REQ-034 Single job: req_0 with x=0x87b21d93...b9589, e=0xaf, m=0xd97a2188...c5885, mul_en=0; engine model done after 8 cycles returning 0xbdb2a4a4...00189 -> gnt_0 one cycle, eng_start one cycle later, res_valid_0=1, result_0=expected, last_latency=8.
REQ-035 Tie: req_0 and req_1 both high from reset -> gnt_0 first; after completion and ack_0, gnt_1; next tie -> gnt_0 (alternation).
REQ-036 Unacked result: req_0 held high, res_ack_0 withheld -> no second gnt_0; req_1 granted; ack_0 -> req_0 granted again.
REQ-037 Sticky done: engine holds eng_done=1 for 5 cycles after completion -> exactly one capture, FSM in DRAIN until done falls, no spurious result.
REQ-038 Reset mid-BUSY: resetn low 2 cycles during job -> all outputs at reset values immediately, res_valid_0=0 after release, new request granted normally.
REQ-039 Saturation: eng_done withheld 70000 cycles -> last_latency=0xFFFF.
